// File: rtl/popcount_pattern_gen_if.sv
// Handshake and result bundle for popcount_pattern_gen.
// The master drives load/count_in; the generator (slave) returns the serial and parallel results.
interface popcount_pattern_gen_if #(
    parameter int N  = 32,
    parameter int CW = 6
);
    logic          load;
    logic [CW-1:0] count_in;
    logic          bit_out;
    logic          bit_valid;
    logic [N-1:0]  data_out;
    logic          busy;
    logic          done;
    logic          clamped;

    modport master (
        output load, count_in,
        input  bit_out, bit_valid, data_out, busy, done, clamped
    );

    modport slave (
        input  load, count_in,
        output bit_out, bit_valid, data_out, busy, done, clamped
    );
endinterface

// File: rtl/popcount_pattern_gen.sv
// Serially builds an N-bit word holding exactly count_in ones, LSB first.
// Define POPGEN_SPREAD_EN to spread the ones evenly instead of packing them low.
//
// state | meaning
// IDLE  | waiting for the first load after reset
// RUN   | generating one bit per clock
// DONE  | word complete and held; load starts the next job
module popcount_pattern_gen #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    popcount_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] N_C  = CW'(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  data;
    logic          bit_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          clamped_q;
    logic          bit_next;

`ifdef POPGEN_SPREAD_EN
    // acc stays below N and cnt <= N, so the sum fits in CW+1 bits
    logic [CW:0] acc;
    logic [CW:0] acc_sum;

    assign acc_sum  = acc + {1'b0, cnt};
    assign bit_next = (acc_sum >= {1'b0, N_C});
`else
    assign bit_next = (idx < cnt);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            data      <= '0;
            bit_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
`ifdef POPGEN_SPREAD_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    bit_q   <= 1'b0;
                    valid_q <= 1'b0;
                    if (bus.load) begin
                        cnt       <= (bus.count_in > N_C) ? N_C : bus.count_in;
                        clamped_q <= (bus.count_in > N_C);
                        done_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        data      <= '0;
                        idx       <= '0;
`ifdef POPGEN_SPREAD_EN
                        acc       <= '0;
`endif
                        state     <= RUN;
                    end
                end
                RUN: begin
                    bit_q   <= bit_next;
                    valid_q <= 1'b1;
                    data    <= {bit_next, data[N-1:1]};
                    idx     <= idx + 1'b1;
`ifdef POPGEN_SPREAD_EN
                    acc     <= bit_next ? (acc_sum - {1'b0, N_C}) : acc_sum;
`endif
                    if (idx == LAST) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = valid_q;
    assign bus.data_out  = data;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.clamped   = clamped_q;
endmodule
